// File: rtl/fetch_queue_unit_if.sv
// Decode-side handshake of the fetch queue: head {pc, instruction} entry
// offered with valid/ready flow control.
interface fetch_queue_unit_if;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_instr;

  modport master (output out_valid, output out_pc, output out_instr, input out_ready);
  modport slave  (input out_valid, input out_pc, input out_instr, output out_ready);
endinterface

// File: rtl/fetch_queue_unit.sv
// Instruction-fetch stage: owns the fetch PC, follows predicted_pc, buffers
// fetched {pc, instruction} pairs toward decode and redirects on mispredict.
module fetch_queue_unit #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          DEPTH    = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [63:0]            predicted_pc,
  input  logic                   resolve_valid,
  input  logic                   prediction_failed,
  input  logic [63:0]            correct_pc,
  output logic [63:0]            imem_addr,
  input  logic [31:0]            imem_rdata,
  output logic [63:0]            current_pc,
  output logic [31:0]            next_instruction,
  fetch_queue_unit_if.master     dq,
  output logic [$clog2(DEPTH):0] count,
  output logic                   flush,
  output logic                   fault,
  output logic [31:0]            mispredict_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t        state_r;
  state_t        state_nx_s;
  logic [63:0]   pc_r;
  logic          flush_r;
  logic          fault_r;
  logic [31:0]   misp_count_r;

  logic [63:0]   pc_mem_r    [DEPTH];
  logic [31:0]   instr_mem_r [DEPTH];
  logic [PW-1:0] head_r;
  logic [PW-1:0] tail_r;
  logic [CW-1:0] count_r;

  logic          redirect_s;
  logic          misaligned_s;
  logic          deq_s;
  logic          enq_s;
  logic          can_accept_s;

  // Next-state, redirect and queue-control decode; redirect beats enqueue and dequeue.
  always_comb begin
    state_nx_s   = state_r;
    redirect_s   = 1'b0;
    misaligned_s = (correct_pc[1:0] != 2'b00);
    deq_s        = 1'b0;
    enq_s        = 1'b0;
    can_accept_s = 1'b0;

    if (state_r == RUN) begin
      redirect_s = resolve_valid & prediction_failed;
    end else begin
      redirect_s = 1'b0;
    end

    deq_s        = (count_r != {CW{1'b0}}) & dq.out_ready & ~redirect_s;
    can_accept_s = (count_r < DEPTH_C) | ((count_r == DEPTH_C) & deq_s);
    enq_s        = (state_r == RUN) & ~redirect_s & can_accept_s;

    case (state_r)
      IDLE:    state_nx_s = RUN;
      RUN: begin
        if (redirect_s & misaligned_s) begin
          state_nx_s = FAULT;
        end else begin
          state_nx_s = RUN;
        end
      end
      FAULT:   state_nx_s = FAULT;
      default: state_nx_s = IDLE;
    endcase
  end

  // FSM state, fetch PC, flush pulse, sticky fault and saturating redirect counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      pc_r         <= RESET_PC;
      flush_r      <= 1'b0;
      fault_r      <= 1'b0;
      misp_count_r <= 32'h0000_0000;
    end else begin
      state_r <= state_nx_s;
      flush_r <= redirect_s;
      // A misaligned target is never loaded: the PC freezes where it was.
      if (redirect_s & ~misaligned_s) begin
        pc_r <= correct_pc;
      end else if (enq_s) begin
        pc_r <= predicted_pc;
      end else begin
        pc_r <= pc_r;
      end
      if (redirect_s && (misp_count_r != 32'hFFFF_FFFF)) begin
        misp_count_r <= misp_count_r + 32'd1;
      end else begin
        misp_count_r <= misp_count_r;
      end
      if ((state_r == RUN) && (state_nx_s == FAULT)) begin
        fault_r <= 1'b1;
      end else begin
        fault_r <= fault_r;
      end
    end
  end

  // Circular fetch queue; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_r  <= {PW{1'b0}};
      tail_r  <= {PW{1'b0}};
      count_r <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_r[i]    <= 64'h0;
        instr_mem_r[i] <= 32'h0;
      end
    end else if (redirect_s) begin
      head_r  <= {PW{1'b0}};
      tail_r  <= {PW{1'b0}};
      count_r <= {CW{1'b0}};
    end else begin
      if (enq_s) begin
        pc_mem_r[tail_r]    <= pc_r;
        instr_mem_r[tail_r] <= imem_rdata;
        tail_r              <= tail_r + PW'(1);
      end else begin
        tail_r <= tail_r;
      end
      if (deq_s) begin
        head_r <= head_r + PW'(1);
      end else begin
        head_r <= head_r;
      end
      case ({enq_s, deq_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign imem_addr        = pc_r;
  assign current_pc       = pc_r;
  assign next_instruction = imem_rdata;
  assign dq.out_valid     = (count_r != {CW{1'b0}});
  assign dq.out_pc        = (count_r != {CW{1'b0}}) ? pc_mem_r[head_r]    : 64'h0;
  assign dq.out_instr     = (count_r != {CW{1'b0}}) ? instr_mem_r[head_r] : 32'h0;
  assign count            = count_r;
  assign flush            = flush_r;
  assign fault            = fault_r;
  assign mispredict_count = misp_count_r;

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Bench for fetch_queue_unit: table-driven fill/stall vectors, directed
// redirect/fault/reset sequences and an in-order decode scoreboard.
module tb_fetch_queue_unit;

  localparam logic [63:0] RPC = 64'h1000;
  localparam logic [31:0] IMEM_KEY = 32'hDEAD_0000;

  logic        clk;
  logic        reset;
  logic [63:0] predicted_pc;
  logic        resolve_valid;
  logic        prediction_failed;
  logic [63:0] correct_pc;
  logic [63:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [63:0] current_pc;
  logic [31:0] next_instruction;
  logic [2:0]  count;
  logic        flush;
  logic        fault;
  logic [31:0] mispredict_count;

  int total = 0;
  int bad   = 0;
  logic [63:0] exp_q[$];

  fetch_queue_unit_if dq ();

  fetch_queue_unit #(.RESET_PC(RPC), .DEPTH(4)) dut (
    .clk               (clk),
    .reset             (reset),
    .predicted_pc      (predicted_pc),
    .resolve_valid     (resolve_valid),
    .prediction_failed (prediction_failed),
    .correct_pc        (correct_pc),
    .imem_addr         (imem_addr),
    .imem_rdata        (imem_rdata),
    .current_pc        (current_pc),
    .next_instruction  (next_instruction),
    .dq                (dq.master),
    .count             (count),
    .flush             (flush),
    .fault             (fault),
    .mispredict_count  (mispredict_count)
  );

  // Simple instruction memory and sequential predictor.
  assign imem_rdata   = imem_addr[31:0] ^ IMEM_KEY;
  assign predicted_pc = current_pc + 64'd4;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic restart(input logic [63:0] base);
    exp_q.delete();
    for (int k = 0; k < 64; k++) exp_q.push_back(base + 64'(4 * k));
  endtask

  // Scoreboard: every decode transfer must be the next expected fetch, in order.
  always @(negedge clk) begin
    if (!reset && dq.out_valid && dq.out_ready && !(resolve_valid && prediction_failed)) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_transfer actual=%h required=none", dq.out_pc);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        chk("deq_pc", dq.out_pc, e);
        chk("deq_instr", {32'h0, dq.out_instr}, {32'h0, e[31:0] ^ IMEM_KEY});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        rdy;
    logic [2:0]  cnt;
    logic [63:0] cur;
    logic        vld;
    logic [63:0] opc;
  } vec_t;

  vec_t tbl [9];

  initial begin
    tbl[0] = '{1'b0, 3'd0, 64'h1000, 1'b0, 64'h0};
    tbl[1] = '{1'b0, 3'd1, 64'h1004, 1'b1, 64'h1000};
    tbl[2] = '{1'b0, 3'd2, 64'h1008, 1'b1, 64'h1000};
    tbl[3] = '{1'b0, 3'd3, 64'h100C, 1'b1, 64'h1000};
    tbl[4] = '{1'b0, 3'd4, 64'h1010, 1'b1, 64'h1000};
    tbl[5] = '{1'b0, 3'd4, 64'h1010, 1'b1, 64'h1000};
    tbl[6] = '{1'b0, 3'd4, 64'h1010, 1'b1, 64'h1000};
    tbl[7] = '{1'b1, 3'd4, 64'h1014, 1'b1, 64'h1004};
    tbl[8] = '{1'b1, 3'd4, 64'h1018, 1'b1, 64'h1008};

    reset = 1'b1;
    dq.out_ready = 1'b0;
    resolve_valid = 1'b0;
    prediction_failed = 1'b0;
    correct_pc = 64'h0;
    restart(RPC);
    tick();
    tick();
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_valid", 64'(dq.out_valid), 64'd0);
    chk("rst_pc", current_pc, RPC);
    chk("rst_out_pc", dq.out_pc, 64'h0);
    chk("rst_flush", 64'(flush), 64'd0);
    chk("rst_fault", 64'(fault), 64'd0);
    chk("rst_misp", 64'(mispredict_count), 64'd0);

    // Fill to full with decode stalled, then resume.
    reset = 1'b0;
    for (int i = 0; i < 9; i++) begin
      dq.out_ready = tbl[i].rdy;
      tick();
      chk($sformatf("tbl%0d_count", i), 64'(count), 64'(tbl[i].cnt));
      chk($sformatf("tbl%0d_cur", i), current_pc, tbl[i].cur);
      chk($sformatf("tbl%0d_valid", i), 64'(dq.out_valid), 64'(tbl[i].vld));
      chk($sformatf("tbl%0d_out_pc", i), dq.out_pc, tbl[i].opc);
    end
    for (int i = 0; i < 6; i++) tick();
    chk("drain_full_count", 64'(count), 64'd4);

    // Reset mid-operation, then steady flow with count 1.
    reset = 1'b1;
    restart(RPC);
    tick();
    chk("rst2_count", 64'(count), 64'd0);
    chk("rst2_pc", current_pc, RPC);
    reset = 1'b0;
    dq.out_ready = 1'b1;
    tick();
    tick();
    chk("flow0_out_pc", dq.out_pc, 64'h1000);
    chk("flow0_count", 64'(count), 64'd1);
    tick();
    chk("flow1_out_pc", dq.out_pc, 64'h1004);
    tick();
    chk("flow2_out_pc", dq.out_pc, 64'h1008);
    chk("flow2_count", 64'(count), 64'd1);

    // Redirect with three entries queued.
    dq.out_ready = 1'b0;
    tick();
    tick();
    chk("pre_redir_count", 64'(count), 64'd3);
    resolve_valid = 1'b1;
    prediction_failed = 1'b1;
    correct_pc = 64'h2000;
    restart(64'h2000);
    tick();
    chk("redir_count", 64'(count), 64'd0);
    chk("redir_flush", 64'(flush), 64'd1);
    chk("redir_misp", 64'(mispredict_count), 64'd1);
    chk("redir_pc", current_pc, 64'h2000);
    resolve_valid = 1'b0;
    prediction_failed = 1'b0;
    dq.out_ready = 1'b1;
    tick();
    chk("refetch_out_pc", dq.out_pc, 64'h2000);
    chk("refetch_count", 64'(count), 64'd1);
    chk("flush_one_cycle", 64'(flush), 64'd0);
    tick();
    tick();

    // Redirect coincident with a decode transfer.
    resolve_valid = 1'b1;
    prediction_failed = 1'b1;
    correct_pc = 64'h3000;
    restart(64'h3000);
    tick();
    chk("coinc_count", 64'(count), 64'd0);
    chk("coinc_flush", 64'(flush), 64'd1);
    chk("coinc_misp", 64'(mispredict_count), 64'd2);
    resolve_valid = 1'b0;
    prediction_failed = 1'b0;
    tick();
    chk("coinc_refetch", dq.out_pc, 64'h3000);

    // Reset with two entries queued.
    dq.out_ready = 1'b0;
    tick();
    chk("pre_rst_count", 64'(count), 64'd2);
    reset = 1'b1;
    restart(RPC);
    tick();
    chk("rst3_count", 64'(count), 64'd0);
    chk("rst3_pc", current_pc, RPC);
    chk("rst3_misp", 64'(mispredict_count), 64'd0);

    // Misaligned redirect freezes fetch.
    reset = 1'b0;
    dq.out_ready = 1'b1;
    tick();
    tick();
    tick();
    resolve_valid = 1'b1;
    prediction_failed = 1'b1;
    correct_pc = 64'h2002;
    exp_q.delete();
    tick();
    chk("fault_set", 64'(fault), 64'd1);
    chk("fault_flush", 64'(flush), 64'd1);
    chk("fault_count", 64'(count), 64'd0);
    chk("fault_pc", current_pc, 64'h1008);
    chk("fault_misp", 64'(mispredict_count), 64'd1);
    resolve_valid = 1'b0;
    prediction_failed = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("fault_hold%0d_pc", i), current_pc, 64'h1008);
      chk($sformatf("fault_hold%0d_count", i), 64'(count), 64'd0);
      chk($sformatf("fault_hold%0d_fault", i), 64'(fault), 64'd1);
    end
    reset = 1'b1;
    restart(RPC);
    tick();
    chk("fault_cleared", 64'(fault), 64'd0);

    // Counter saturation.
    reset = 1'b0;
    tick();
    tick();
    tick();
    force dut.misp_count_r = 32'hFFFF_FFFF;
    #1;
    release dut.misp_count_r;
    resolve_valid = 1'b1;
    prediction_failed = 1'b1;
    correct_pc = 64'h4000;
    restart(64'h4000);
    tick();
    chk("sat_misp", 64'(mispredict_count), 64'hFFFF_FFFF);
    chk("sat_flush", 64'(flush), 64'd1);
    resolve_valid = 1'b0;
    prediction_failed = 1'b0;
    tick();
    tick();
    chk("sat_refetch_misp", 64'(mispredict_count), 64'hFFFF_FFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
